// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter sharing one sdram_controller request interface.
// Define SDRAM_ARB_FIXED_PRIO_EN to make client 0 always win a tie instead.
module sdram_port_arbiter #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 128
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              ic0_req,
   input  logic              ic1_req,
   input  logic              ic0_we,
   input  logic              ic1_we,
   input  logic [ADDR_W-1:0] ic0_addr,
   input  logic [ADDR_W-1:0] ic1_addr,
   input  logic [DATA_W-1:0] ic0_wdata,
   input  logic [DATA_W-1:0] ic1_wdata,
   output logic              oc0_ack,
   output logic              oc1_ack,
   output logic [DATA_W-1:0] oc0_rdata,
   output logic [DATA_W-1:0] oc1_rdata,
   output logic              octl_write_req,
   output logic [ADDR_W-1:0] octl_write_address,
   output logic [DATA_W-1:0] octl_write_data,
   input  logic              ictl_write_ack,
   output logic              octl_read_req,
   output logic [ADDR_W-1:0] octl_read_address,
   input  logic [DATA_W-1:0] ictl_read_data,
   input  logic              ictl_read_ack,
   input  logic              ictl_init_done,
   output logic              obusy,
   output logic              ogrant
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      ISSUE = 3'b010,
      DONE  = 3'b100
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wr_req_q, wr_req_d;
   logic                rd_req_q, rd_req_d;
   logic                ack0_q, ack0_d;
   logic                ack1_q, ack1_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;

   logic                both_req;
   logic                sel;
   logic                sel_we;
   logic                ctl_ack;

   assign both_req = ic0_req & ic1_req;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
   assign sel = both_req ? 1'b0 : ic1_req;
`else
   assign sel = both_req ? ~last_grant_q : ic1_req;
`endif
   assign sel_we  = sel ? ic1_we : ic0_we;
   // Only the ack matching the issued direction counts; the other is a stray.
   assign ctl_ack = we_q ? ictl_write_ack : ictl_read_ack;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_req_d     = wr_req_q;
      rd_req_d     = rd_req_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      case (state_q)
         IDLE: begin
            if (ictl_init_done && (ic0_req || ic1_req)) begin
               grant_d      = sel;
               last_grant_d = sel;
               we_d         = sel_we;
               addr_d       = sel ? ic1_addr : ic0_addr;
               wdata_d      = sel ? ic1_wdata : ic0_wdata;
               wr_req_d     = sel_we;
               rd_req_d     = ~sel_we;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (ctl_ack) begin
               wr_req_d = 1'b0;
               rd_req_d = 1'b0;
               if (!we_q) begin
                  if (grant_q) rdata1_d = ictl_read_data;
                  else         rdata0_d = ictl_read_data;
               end
               ack0_d  = ~grant_q;
               ack1_d  = grant_q;
               state_d = DONE;
            end
         end
         // DONE never samples requests, giving the client a cycle to drop req.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wr_req_q     <= 1'b0;
         rd_req_q     <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_req_q     <= wr_req_d;
         rd_req_q     <= rd_req_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign oc0_ack            = ack0_q;
   assign oc1_ack            = ack1_q;
   assign oc0_rdata          = rdata0_q;
   assign oc1_rdata          = rdata1_q;
   assign octl_write_req     = wr_req_q;
   assign octl_read_req      = rd_req_q;
   assign octl_write_address = addr_q;
   assign octl_read_address  = addr_q;
   assign octl_write_data    = wdata_q;
   assign obusy              = (state_q != IDLE);
   assign ogrant             = grant_q;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-client arbiter in front of `sdram_controller`. It shares the controller's single read/write request interface between two independent requesters, for example a frame writer and a display reader. Each client gets a unified request/ack port with one outstanding transaction. The arbiter serialises the clients round-robin, drives the matching controller request until that request's ack arrives, and returns read data to the granted client.

## Interface
Parameters:
- `ADDR_W`, 22: client/controller word address width (bank, row, column[9:3]).
- `DATA_W`, 128: burst data width (8 x 16-bit beats).

Ports:
- `iclk`  in  1  — single clock domain, shared with `sdram_controller`.
- `ireset`  in  1  — asynchronous, active-high reset.
- `ic0_req`, `ic1_req`  in  1 each  — client request. Held high until that client's `oc*_ack`.
- `ic0_we`, `ic1_we`  in  1 each  — 1 = write, 0 = read. Held stable while req is high.
- `ic0_addr`, `ic1_addr`  in  ADDR_W each  — transaction address. Held stable while req is high.
- `ic0_wdata`, `ic1_wdata`  in  DATA_W each  — write data. Held stable while req is high.
- `oc0_ack`, `oc1_ack`  out  1 each  — one-cycle completion pulse.
- `oc0_rdata`, `oc1_rdata`  out  DATA_W each  — read data, registered. Valid from the ack cycle until that client's next read completes.
- `octl_write_req`  out  1  — connects to controller `iwrite_req`.
- `octl_write_address`  out  ADDR_W  — connects to controller write address.
- `octl_write_data`  out  DATA_W  — connects to controller write data.
- `ictl_write_ack`  in  1  — from controller `owrite_ack`.
- `octl_read_req`  out  1  — connects to controller `iread_req`.
- `octl_read_address`  out  ADDR_W  — connects to controller read address.
- `ictl_read_data`  in  DATA_W  — from controller read data.
- `ictl_read_ack`  in  1  — from controller `oread_ack`.
- `ictl_init_done`  in  1  — from controller `oinit_done`.
- `obusy`  out  1  — high in every state except IDLE.
- `ogrant`  out  1  — index of the current or last granted client.

## Operation
- FSM: IDLE → ISSUE → DONE → IDLE. One-hot, 3 bits.
- Reset values:
  - state = IDLE; `last_grant` = 1, so client 0 wins the first tie.
  - All outputs 0, including `oc*_rdata`, `octl_*` address/data, and `ogrant`.
- IDLE:
  - No grant while `ictl_init_done` = 0.
  - Otherwise sample `ic0_req`/`ic1_req`.
  - Exactly one request high: grant that client.
  - Both high: grant `!last_grant` (round-robin).
  - On grant, in the same edge:
    - latch `ogrant`, `we`, `addr` and `wdata` into controller-side registers;
    - assert `octl_write_req` if `we` = 1, else `octl_read_req`;
    - update `last_grant`;
    - go to ISSUE.
- ISSUE:
  - Hold the latched request and address/data stable.
  - Ignore the ack of the direction not issued.
  - On `ictl_write_ack` for a write, or `ictl_read_ack` for a read:
    - clear the controller request in the same edge;
    - for a read, capture `ictl_read_data` into the granted client's `oc*_rdata`;
    - go to DONE.
- DONE:
  - Pulse `oc<ogrant>_ack` for exactly one cycle, then return to IDLE.
  - Requests are never sampled in DONE. This gives the client one cycle to drop req after seeing ack.
- The non-granted client's req is left pending. It wins the next IDLE arbitration, so it waits at most one transaction.
- Client protocol violation (req dropped while granted): the transaction still completes; the ack is still pulsed.
- Reset mid-transaction:
  - return to IDLE immediately with outputs at reset values;
  - the controller is reset by the same `ireset`, so no dangling transaction exists.

## Timing
- Request seen high at IDLE edge t:
  - controller req is high from t+1;
  - the controller enters its request state on its next edge.
- Controller ack high at edge a: controller req is low from a+1 and client ack is high during a+1. The controller sees req low in its idle cycle, so it never issues a duplicate.
- Client-visible latency is controller latency + 2 cycles.
- Back-to-back transactions: the minimum gap between controller requests is 2 cycles (DONE, IDLE).
- `oc*_rdata` updates at the same edge that raises `oc*_ack`.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN`:
  - Defined: client 0 always wins when both request. `last_grant` is still tracked for `ogrant` but is not used for selection.
  - Undefined (default): round-robin as described above.

## Test plan
- Hold `ictl_init_done` = 0 with `ic0_req` high for 20 cycles → `octl_*_req` stays 0. Raise init_done → `octl_write_req` = 1 one cycle later.
- Client 0 write, addr 22'h000010, wdata 128'hA5…A5; controller model acks after 12 cycles → `octl_write_data` = A5…A5 throughout ISSUE; `oc0_ack` pulses once, one cycle after the ack; `octl_write_req` low on the ack+1 cycle.
- Client 1 read, addr 22'h3FFFFF; model returns 128'h0123…CDEF with `ictl_read_ack` → `oc1_rdata` = 0123…CDEF at the `oc1_ack` cycle; `oc0_rdata` unchanged.
- Both clients request continuously for 6 transactions → grants are 0,1,0,1,0,1. With `SDRAM_ARB_FIXED_PRIO_EN` → 0,0,0,0,0,0.
- Stray `ictl_read_ack` during an issued write → ignored, state stays ISSUE, no client ack.
- Assert `ireset` mid-ISSUE → next sampled values: `obusy` = 0, all `octl_*_req` = 0, `ogrant` = 0. After release, client 0 wins a tie.
